// File: rtl/ip_sdram_arbiter.sv
// ip_sdram_arbiter: shares the single ip_sdram port among VDP, CPU and DMA.
// One command is granted per slot; read words are routed back to their owner.
module ip_sdram_arbiter #(
  parameter int RD_LATENCY     = 4,
  parameter int VDP_MAX_CONSEC = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exec,
  input  logic        sdram_busy,
  output logic [22:0] sdram_address,
  output logic        sdram_is_write,
  output logic [7:0]  sdram_wdata,
  input  logic [15:0] sdram_rdata,
  input  logic        vdp_req,
  input  logic [22:0] vdp_address,
  output logic        vdp_ack,
  output logic [15:0] vdp_rdata,
  output logic        vdp_rdata_en,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [22:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rdata_en,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [22:0] dma_address,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic        dma_rdata_en
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VDP  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_DMA  = 2'd3;

  localparam int CW = $clog2(VDP_MAX_CONSEC + 1);
  localparam logic [CW-1:0] CMAX = CW'(VDP_MAX_CONSEC);

  typedef struct packed {
    logic       rd;
    logic [1:0] who;
  } owner_t;

  logic          issue;
  logic          vdp_block;
  logic          g_vdp, g_cpu, g_dma;
  logic [CW-1:0] vdp_consec, nxt_consec;
  logic          rr_dma, nxt_rr;
  logic [22:0]   nxt_addr;
  logic          nxt_wr;
  logic [7:0]    nxt_wdata;
  owner_t        cur_owner, nxt_owner;
  owner_t        dline [RD_LATENCY];
  owner_t        ret;

  assign issue = exec & ~sdram_busy;

  // Grant terms are mutually exclusive so the decoder below is truly unique.
  always_comb begin
    vdp_block = (vdp_consec == CMAX) && (cpu_req || dma_req);
    g_vdp = vdp_req & ~vdp_block;
    g_cpu = ~g_vdp & cpu_req & (~dma_req | ~rr_dma);
    g_dma = ~g_vdp & dma_req & ~g_cpu;
  end

  always_comb begin
    nxt_addr   = sdram_address;
    nxt_wr     = 1'b0;
    nxt_wdata  = sdram_wdata;
    nxt_owner  = '{rd: 1'b0, who: OWN_NONE};
    nxt_consec = '0;
    nxt_rr     = rr_dma;
    unique case (1'b1)
      g_vdp: begin
        nxt_addr   = vdp_address;
        nxt_owner  = '{rd: 1'b1, who: OWN_VDP};
        nxt_consec = (vdp_consec == CMAX) ?
                     CMAX : vdp_consec + CW'(1);
      end
      g_cpu: begin
        nxt_addr  = cpu_address;
        nxt_wr    = cpu_write;
        nxt_wdata = cpu_wdata;
        nxt_owner = '{rd: ~cpu_write, who: OWN_CPU};
        nxt_rr    = 1'b1;
      end
      g_dma: begin
        nxt_addr  = dma_address;
        nxt_wr    = dma_write;
        nxt_wdata = dma_wdata;
        nxt_owner = '{rd: ~dma_write, who: OWN_DMA};
        nxt_rr    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdram_address  <= '0;
      sdram_is_write <= 1'b0;
      sdram_wdata    <= '0;
      cur_owner      <= '0;
      vdp_consec     <= '0;
      rr_dma         <= 1'b0;
      vdp_ack        <= 1'b0;
      cpu_ack        <= 1'b0;
      dma_ack        <= 1'b0;
    end else begin
      vdp_ack <= issue & g_vdp;
      cpu_ack <= issue & g_cpu;
      dma_ack <= issue & g_dma;
      if (issue) begin
        sdram_address  <= nxt_addr;
        sdram_is_write <= nxt_wr;
        sdram_wdata    <= nxt_wdata;
        cur_owner      <= nxt_owner;
        vdp_consec     <= nxt_consec;
        rr_dma         <= nxt_rr;
      end
    end
  end

  // Owner of each consumed read travels alongside the controller pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) dline[i] <= '0;
      ret <= '0;
    end else begin
      dline[0] <= (issue && cur_owner.rd) ? cur_owner : '0;
      for (int i = 1; i < RD_LATENCY; i++) dline[i] <= dline[i-1];
      ret <= dline[RD_LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vdp_rdata    <= '0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
      vdp_rdata_en <= 1'b0;
      cpu_rdata_en <= 1'b0;
      dma_rdata_en <= 1'b0;
    end else begin
      vdp_rdata_en <= ret.rd && (ret.who == OWN_VDP);
      cpu_rdata_en <= ret.rd && (ret.who == OWN_CPU);
      dma_rdata_en <= ret.rd && (ret.who == OWN_DMA);
      if (ret.rd && ret.who == OWN_VDP) vdp_rdata <= sdram_rdata;
      if (ret.rd && ret.who == OWN_CPU) cpu_rdata <= sdram_rdata;
      if (ret.rd && ret.who == OWN_DMA) dma_rdata <= sdram_rdata;
    end
  end

endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// tb_ip_sdram_arbiter: directed and random stimulus against a slot-level
// model of the arbiter with a byte-array SDRAM behind it.
module tb_ip_sdram_arbiter;

  localparam int L    = 4;
  localparam int MAXC = 3;
  localparam int NONE = 0, V = 1, C = 2, D = 3;

  logic        clk = 1'b0;
  logic        reset, exec, sdram_busy;
  logic [22:0] sdram_address;
  logic        sdram_is_write;
  logic [7:0]  sdram_wdata;
  logic [15:0] sdram_rdata;
  logic        vdp_ack, cpu_ack, dma_ack;
  logic [15:0] vdp_rdata, cpu_rdata, dma_rdata;
  logic        vdp_rdata_en, cpu_rdata_en, dma_rdata_en;

  logic        r_req [4];
  logic        r_wr  [4];
  logic [22:0] r_addr[4];
  logic [7:0]  r_wd  [4];

  ip_sdram_arbiter #(.RD_LATENCY(L), .VDP_MAX_CONSEC(MAXC)) dut (
    .clk(clk), .reset(reset), .exec(exec), .sdram_busy(sdram_busy),
    .sdram_address(sdram_address), .sdram_is_write(sdram_is_write),
    .sdram_wdata(sdram_wdata), .sdram_rdata(sdram_rdata),
    .vdp_req(r_req[V]), .vdp_address(r_addr[V]), .vdp_ack(vdp_ack),
    .vdp_rdata(vdp_rdata), .vdp_rdata_en(vdp_rdata_en),
    .cpu_req(r_req[C]), .cpu_write(r_wr[C]), .cpu_address(r_addr[C]),
    .cpu_wdata(r_wd[C]), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_rdata_en(cpu_rdata_en),
    .dma_req(r_req[D]), .dma_write(r_wr[D]), .dma_address(r_addr[D]),
    .dma_wdata(r_wd[D]), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .dma_rdata_en(dma_rdata_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ecnt = 0;

  // model state
  logic [7:0]  mem [int];
  logic [22:0] m_addr;
  logic        m_wr;
  logic [7:0]  m_wdata;
  int          m_own, m_consec, m_rr, last_grant;
  logic        e_ack [4];
  logic        e_en  [4];
  logic [15:0] e_rdata [4];
  int          dv_own [int];
  logic [15:0] dv_word [int];
  logic [15:0] drv [int];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic chk_s(string nm, string act, string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%s required=%s", nm, act, exp);
    end
  endtask

  task automatic tmo(string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout cyc=%0d", nm, cyc);
  endtask

  function automatic logic [7:0] rdmem(int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic int pick();
    bit others = r_req[C] || r_req[D];
    if (r_req[V] && !(m_consec == MAXC && others)) return V;
    if (r_req[C] && r_req[D]) return m_rr;
    if (r_req[C]) return C;
    if (r_req[D]) return D;
    return NONE;
  endfunction

  task automatic mreset();
    m_addr = '0; m_wr = 1'b0; m_wdata = '0;
    m_own = NONE; m_consec = 0; m_rr = C;
    for (int i = 0; i < 4; i++) begin
      e_ack[i] = 1'b0; e_en[i] = 1'b0; e_rdata[i] = '0;
    end
    dv_own.delete(); dv_word.delete(); drv.delete();
  endtask

  task automatic model_edge();
    int a, g;
    logic [15:0] w;
    last_grant = -1;
    for (int i = 0; i < 4; i++) begin
      e_ack[i] = 1'b0; e_en[i] = 1'b0;
    end
    if (reset) begin
      mreset();
      return;
    end
    if (dv_own.exists(cyc)) begin
      e_rdata[dv_own[cyc]] = dv_word[cyc];
      e_en[dv_own[cyc]] = 1'b1;
    end
    if (exec && !sdram_busy) begin
      a = int'(m_addr);
      if (m_own != NONE && m_wr) mem[a] = m_wdata;
      else if (m_own != NONE) begin
        w = {rdmem(a | 1), rdmem(a & ~1)};
        dv_own[cyc + L + 1] = m_own;
        dv_word[cyc + L + 1] = w;
        drv[cyc + L] = w;
      end
      g = pick();
      last_grant = g;
      if (g == NONE) begin
        m_wr = 1'b0; m_own = NONE; m_consec = 0;
      end else begin
        e_ack[g] = 1'b1;
        m_addr = r_addr[g];
        m_own = g;
        if (g == V) begin
          m_wr = 1'b0;
          if (m_consec < MAXC) m_consec++;
        end else begin
          m_wr = r_wr[g];
          m_wdata = r_wd[g];
          m_consec = 0;
          m_rr = (g == C) ? D : C;
        end
      end
    end
  endtask

  task automatic compare();
    chk("vdp_ack", vdp_ack, e_ack[V]);
    chk("cpu_ack", cpu_ack, e_ack[C]);
    chk("dma_ack", dma_ack, e_ack[D]);
    chk("sdram_address", sdram_address, m_addr);
    chk("sdram_is_write", sdram_is_write, m_wr);
    if (m_wr) chk("sdram_wdata", sdram_wdata, m_wdata);
    chk("vdp_rdata_en", vdp_rdata_en, e_en[V]);
    chk("cpu_rdata_en", cpu_rdata_en, e_en[C]);
    chk("dma_rdata_en", dma_rdata_en, e_en[D]);
    chk("vdp_rdata", vdp_rdata, e_rdata[V]);
    chk("cpu_rdata", cpu_rdata, e_rdata[C]);
    chk("dma_rdata", dma_rdata, e_rdata[D]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    compare();
    sdram_rdata = drv.exists(cyc) ? drv[cyc] : 16'($urandom);
    ecnt++;
    exec = (ecnt % 4 == 0);
  endtask

  task automatic txn(int who, bit wr, int addr, int wd);
    int n = 0;
    r_req[who] = 1'b1; r_wr[who] = wr;
    r_addr[who] = 23'(addr); r_wd[who] = 8'(wd);
    do begin step(); n++; end
    while (last_grant != who && n < 12);
    if (last_grant != who) tmo("txn_ack");
    r_req[who] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    string s;
    int n, k, cnt;
    logic [22:0] held;
    bit eb;
    reset = 1'b1; exec = 1'b0; sdram_busy = 1'b0;
    sdram_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      r_req[i] = 1'b0; r_wr[i] = 1'b0;
      r_addr[i] = '0; r_wd[i] = '0;
    end
    mreset();
    step(); step();
    chk("rst_addr", sdram_address, 0);
    chk("rst_wr", sdram_is_write, 0);
    chk("rst_wdata", sdram_wdata, 0);
    reset = 1'b0;

    // CPU write 0x45 @ 3, then held for the slot
    txn(C, 1, 3, 'h45);
    chk("t1_ack", cpu_ack, 1);
    chk("t1_wr", sdram_is_write, 1);
    chk("t1_addr", sdram_address, 23'h3);
    chk("t1_wdata", sdram_wdata, 8'h45);
    repeat (3) begin
      step();
      chk("t1_hold_addr", sdram_address, 23'h3);
      chk("t1_hold_wdata", sdram_wdata, 8'h45);
      chk("t1_no_en", cpu_rdata_en, 0);
    end
    txn(C, 1, 2, 'h34);
    txn(C, 0, 2, 0);
    k = 0; cnt = 0;
    do begin step(); k++; end
    while (!cpu_rdata_en && k < 30);
    chk("t2_latency", k, 4 + L + 1);
    chk("t2_rdata", cpu_rdata, 16'h4534);
    repeat (10) begin step(); if (cpu_rdata_en) cnt++; end
    chk("t2_single_en", cnt, 0);

    // all three pending for ten slots
    do_reset();
    r_addr[V] = 23'h100; r_addr[C] = 23'h2; r_addr[D] = 23'h3;
    r_wr[C] = 1'b0; r_wr[D] = 1'b0;
    r_req[V] = 1'b1; r_req[C] = 1'b1; r_req[D] = 1'b1;
    s = ""; n = 0;
    while (s.len() < 10 && n < 100) begin
      step(); n++;
      if (vdp_ack) s = {s, "V"};
      else if (cpu_ack) s = {s, "C"};
      else if (dma_ack) s = {s, "D"};
    end
    chk_s("t3_order", s, "VVVCVVVDVV");
    r_req[V] = 1'b0;
    s = ""; n = 0;
    while (s.len() < 4 && n < 60) begin
      step(); n++;
      if (cpu_ack) s = {s, "C"};
      else if (dma_ack) s = {s, "D"};
    end
    chk_s("t4_order", s, "CDCD");
    r_req[C] = 1'b0; r_req[D] = 1'b0;
    repeat (16) step();

    // busy freezes the slot
    held = sdram_address;
    sdram_busy = 1'b1;
    r_req[C] = 1'b1; r_wr[C] = 1'b1;
    r_addr[C] = 23'h5; r_wd[C] = 8'h77;
    cnt = 0;
    repeat (20) begin
      step();
      if (cpu_ack) cnt++;
      chk("t5_addr_hold", sdram_address, held);
    end
    chk("t5_no_ack", cnt, 0);
    sdram_busy = 1'b0;
    n = 0;
    do begin eb = exec; step(); n++; end
    while (!eb && n < 8);
    chk("t5_first_exec_grant", cpu_ack, 1);
    r_req[C] = 1'b0;
    repeat (4) step();

    // reset shortly after a VDP read is consumed
    txn(V, 0, 'h10, 0);
    n = 0;
    do begin eb = exec; step(); n++; end
    while (!eb && n < 8);
    step(); step();
    reset = 1'b1;
    #1;
    chk("t6_addr0", sdram_address, 0);
    chk("t6_acks0", {vdp_ack, cpu_ack, dma_ack}, 0);
    chk("t6_en0", {vdp_rdata_en, cpu_rdata_en, dma_rdata_en}, 0);
    chk("t6_rdata0", cpu_rdata, 0);
    step(); step();
    reset = 1'b0;
    cnt = 0;
    repeat (15) begin step(); if (vdp_rdata_en) cnt++; end
    chk("t6_no_vdp_en", cnt, 0);

    // random traffic
    repeat (2400) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      if ($urandom_range(0, 19) == 0) sdram_busy = ~sdram_busy;
      for (int r = 1; r < 4; r++) begin
        if (e_ack[r]) r_req[r] = 1'b0;
        else if (r_req[r]) begin
          if ($urandom_range(0, 15) == 0) r_req[r] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r_req[r] = 1'b1;
          r_addr[r] = 23'($urandom_range(0, 15));
          r_wr[r] = (r == V) ? 1'b0 : 1'($urandom);
          r_wd[r] = 8'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
